// File: rtl/pcr_arbiter_pkg.sv
// pcr_arbiter_pkg
//   Shared definitions for the PCR port arbiter: control_processor command
//   encodings, PCR addresses, and the arbiter state encoding.
//   Imported by pcr_arbiter (and usable by any block that talks to the
//   control_processor PCR port).
package pcr_arbiter_pkg;

  // control_processor PCR command encodings (2-bit funct3 subset).
  localparam logic [1:0] F3_MTPCR    = 2'd1;
  localparam logic [1:0] F3_SETPCR   = 2'd2;
  localparam logic [1:0] F3_CLEARPCR = 2'd3;

  // PCR addresses.
  localparam logic [4:0] PCR_STATUS   = 5'd0;
  localparam logic [4:0] PCR_EPC      = 5'd1;
  localparam logic [4:0] PCR_BADVADDR = 5'd2;
  localparam logic [4:0] PCR_EVEC     = 5'd3;
  localparam logic [4:0] PCR_COUNT    = 5'd4;
  localparam logic [4:0] PCR_COMPARE  = 5'd5;
  localparam logic [4:0] PCR_CAUSE    = 5'd6;
  localparam logic [4:0] PCR_PTBR     = 5'd7;
  localparam logic [4:0] PCR_K0       = 5'd12;
  localparam logic [4:0] PCR_K1       = 5'd13;
  localparam logic [4:0] PCR_TOHOST   = 5'd30;
  localparam logic [4:0] PCR_FROMHOST = 5'd31;

  // Arbiter state: either free for a host grant, or holding a host response.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  // A core op only really uses the port when it is present and not stalled;
  // a stalled core op can be displaced by the host without losing anything.
  function automatic logic core_op_active(input logic enable, input logic stall);
    return enable & ~stall;
  endfunction

endpackage

// File: rtl/pcr_arbiter.sv
// pcr_arbiter
//   Shares the single control_processor PCR port between the execute-stage
//   core PCR ops (mtpcr/setpcr/clearpcr) and the host interface
//   (tohost/fromhost debug and boot traffic). The core has priority; a host
//   access uses the port for one cycle and then presents a held response.
//
// Configuration
//   PCR_ARB_STARVE_GUARD_EN  when defined, a starvation counter forces the
//                            host in after STARVE_LIMIT consecutive blocked
//                            cycles (STARVE_LIMIT parameter exists only then).
//                            When undefined, priority is strictly core-first.
//
// Ports
//   clk, reset                     core clock, async active-high reset
//   core_enable/stall/cmd/pcr/wdata core PCR op from the pipeline
//   core_rdata, core_hold          read data back to core, retry request
//   host_req_*                     host request channel (valid/ready)
//   host_resp_*                    host response channel (valid/ready)
//   cp_enable/stall/cmd/pcr/wdata  drive the control_processor PCR port
//   cp_rdata                       control_processor pcr_data
module pcr_arbiter
  import pcr_arbiter_pkg::*;
`ifdef PCR_ARB_STARVE_GUARD_EN
#(
  parameter int unsigned STARVE_LIMIT = 8
)
`endif
(
  input  logic        clk,
  input  logic        reset,

  input  logic        core_stall,
  input  logic        core_enable,
  input  logic [1:0]  core_cmd,
  input  logic [4:0]  core_pcr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_hold,

  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic        host_req_write,
  input  logic [4:0]  host_req_pcr,
  input  logic [31:0] host_req_wdata,

  output logic        host_resp_valid,
  input  logic        host_resp_ready,
  output logic [31:0] host_resp_data,

  output logic        cp_enable,
  output logic        cp_stall,
  output logic [1:0]  cp_cmd,
  output logic [4:0]  cp_pcr,
  output logic [31:0] cp_wdata,
  input  logic [31:0] cp_rdata
);

  arb_state_e state;
  logic       core_active;
  logic       force_host;
  logic       host_slot;
  logic       host_grant;

  assign core_active = core_op_active(core_enable, core_stall);

`ifdef PCR_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign force_host = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts consecutive idle cycles where a waiting host lost to an active
  // core. Once it reaches the limit the host is forced in for one grant.
  // A dropped request resets the count so only back-to-back losses count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (host_grant || !host_req_valid) begin
      starve_cnt <= '0;
    end else if ((state == ARB_IDLE) && core_active && !force_host) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign force_host = 1'b0;
`endif

  // The host may only use the port from IDLE, and only when the core is not
  // actively using it (or when starvation forces it in). Ready is offered
  // whether or not the host is currently asking.
  assign host_slot      = (state == ARB_IDLE) & (~core_active | force_host);
  assign host_req_ready = host_slot;
  assign host_grant     = host_slot & host_req_valid;

  // A core op present during a host grant must be retried; a stalled core op
  // displaced this way is held too so the pipeline does not see stale data.
  assign core_hold  = host_grant & core_enable;
  assign core_rdata = core_hold ? 32'h0 : cp_rdata;

  // Port mux. Host accesses are always issued as MTPCR; a read sets cp_stall
  // so the write is suppressed while pcr_data still shows the current value
  // combinationally. A write likewise returns the pre-write value.
  always_comb begin
    cp_enable = core_enable;
    cp_stall  = core_stall;
    cp_cmd    = core_cmd;
    cp_pcr    = core_pcr;
    cp_wdata  = core_wdata;
    if (host_grant) begin
      cp_enable = 1'b1;
      cp_stall  = ~host_req_write;
      cp_cmd    = F3_MTPCR;
      cp_pcr    = host_req_pcr;
      cp_wdata  = host_req_wdata;
    end
  end

  // Host transaction FSM. The response value is captured on the grant edge
  // and held until the host takes it; the core is not blocked while the
  // response waits. A reset abandons any response in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ARB_IDLE;
      host_resp_valid <= 1'b0;
      host_resp_data  <= 32'h0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (host_grant) begin
            state           <= ARB_RESP;
            host_resp_valid <= 1'b1;
            host_resp_data  <= cp_rdata;
          end
        end
        ARB_RESP: begin
          if (host_resp_ready) begin
            state           <= ARB_IDLE;
            host_resp_valid <= 1'b0;
          end
        end
        default: begin
          state           <= ARB_IDLE;
          host_resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcr_arbiter.sv
// tb_pcr_arbiter
//   Directed self-checking bench for pcr_arbiter. A small behavioural
//   control_processor (PCR register file, flush_tlb on PTBR writes) sits on
//   the cp_* port so host and core accesses have real side effects.
//   Honours PCR_ARB_STARVE_GUARD_EN for the starvation scenario.
module tb_pcr_arbiter;
  import pcr_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_stall, core_enable;
  logic [1:0]  core_cmd;
  logic [4:0]  core_pcr;
  logic [31:0] core_wdata, core_rdata;
  logic        core_hold;
  logic        host_req_valid, host_req_ready, host_req_write;
  logic [4:0]  host_req_pcr;
  logic [31:0] host_req_wdata;
  logic        host_resp_valid, host_resp_ready;
  logic [31:0] host_resp_data;
  logic        cp_enable, cp_stall;
  logic [1:0]  cp_cmd;
  logic [4:0]  cp_pcr;
  logic [31:0] cp_wdata, cp_rdata;

  logic [31:0] pcr_regs [32];
  logic        flush_tlb;

  int checks = 0;
  int fails  = 0;

  pcr_arbiter dut (
    .clk(clk), .reset(reset),
    .core_stall(core_stall), .core_enable(core_enable), .core_cmd(core_cmd),
    .core_pcr(core_pcr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_hold(core_hold),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_write(host_req_write), .host_req_pcr(host_req_pcr),
    .host_req_wdata(host_req_wdata),
    .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
    .host_resp_data(host_resp_data),
    .cp_enable(cp_enable), .cp_stall(cp_stall), .cp_cmd(cp_cmd),
    .cp_pcr(cp_pcr), .cp_wdata(cp_wdata), .cp_rdata(cp_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural control_processor: combinational read, write on the edge
  // unless stalled, EVEC resets to 0x100.
  assign cp_rdata  = pcr_regs[cp_pcr];
  assign flush_tlb = cp_enable & ~cp_stall & (cp_cmd == 2'd1) & (cp_pcr == 5'd7);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) pcr_regs[i] <= 32'h0;
      pcr_regs[3] <= 32'h100;
    end else if (cp_enable && !cp_stall) begin
      case (cp_cmd)
        2'd1: pcr_regs[cp_pcr] <= cp_wdata;
        2'd2: pcr_regs[cp_pcr] <= pcr_regs[cp_pcr] | cp_wdata;
        2'd3: pcr_regs[cp_pcr] <= pcr_regs[cp_pcr] & ~cp_wdata;
        default: ;
      endcase
    end
  end

  task automatic idle_inputs();
    core_stall = 0; core_enable = 0; core_cmd = 0; core_pcr = 0; core_wdata = 0;
    host_req_valid = 0; host_req_write = 0; host_req_pcr = 0; host_req_wdata = 0;
    host_resp_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    checks++; if (host_resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_valid: got %0h want 0", host_resp_valid); end
    checks++; if (host_resp_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_data: got %0h want 0", host_resp_data); end
    checks++; if (host_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_ready: got %0h want 1", host_req_ready); end
    @(negedge clk); reset = 1'b0;
    // Enter ARB_RESP with a read of EVEC, then reset asynchronously mid-response.
    @(negedge clk);
    host_req_valid = 1; host_req_write = 0; host_req_pcr = 5'd3;
    tick();
    host_req_valid = 0;
    checks++; if (host_resp_data !== 32'h100) begin fails++; $display("[TB] FAIL mid_data: got %0h want 100", host_resp_data); end
    #2 reset = 1'b1;
    #1;
    checks++; if (host_resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL arst_valid: got %0h want 0", host_resp_valid); end
    checks++; if (host_resp_data !== 32'h0) begin fails++; $display("[TB] FAIL arst_data: got %0h want 0", host_resp_data); end
    @(negedge clk); reset = 1'b0;
    tick();
    checks++; if (host_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL arst_ready: got %0h want 1", host_req_ready); end
    checks++; if (host_resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL arst_valid2: got %0h want 0", host_resp_valid); end
  endtask

  task automatic test_host_write();
    @(negedge clk);
    host_req_valid = 1; host_req_write = 1; host_req_pcr = 5'd12; host_req_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (host_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL wr_ready: got %0h want 1", host_req_ready); end
    checks++; if ({cp_enable, cp_stall, cp_cmd, cp_pcr} !== {1'b1, 1'b0, 2'd1, 5'd12}) begin fails++; $display("[TB] FAIL wr_cp: got %0h want %0h", {cp_enable, cp_stall, cp_cmd, cp_pcr}, {1'b1, 1'b0, 2'd1, 5'd12}); end
    tick();
    host_req_valid = 0;
    checks++; if (host_resp_valid !== 1'b1) begin fails++; $display("[TB] FAIL wr_rvalid: got %0h want 1", host_resp_valid); end
    checks++; if (host_resp_data !== 32'h0) begin fails++; $display("[TB] FAIL wr_old: got %0h want 0", host_resp_data); end
    checks++; if (host_req_ready !== 1'b0) begin fails++; $display("[TB] FAIL wr_resp_ready: got %0h want 0", host_req_ready); end
    host_resp_ready = 1;
    tick();
    host_resp_ready = 0;
    checks++; if (host_resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL wr_done: got %0h want 0", host_resp_valid); end
    @(negedge clk);
    host_req_valid = 1; host_req_write = 0; host_req_pcr = 5'd12;
    tick();
    host_req_valid = 0;
    checks++; if (host_resp_data !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL rd_k0: got %0h want deadbeef", host_resp_data); end
    host_resp_ready = 1;
    tick();
    host_resp_ready = 0;
  endtask

  task automatic test_hold_response();
    @(negedge clk);
    host_req_valid = 1; host_req_write = 0; host_req_pcr = 5'd3; host_req_wdata = 32'h12345678;
    #1;
    checks++; if (cp_stall !== 1'b1) begin fails++; $display("[TB] FAIL rd_stall: got %0h want 1", cp_stall); end
    tick();
    host_req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      // The core passes through while the response waits.
      @(negedge clk);
      core_enable = 1; core_stall = 1; core_pcr = 5'd13;
      #1;
      checks++; if ({host_resp_valid, host_resp_data} !== {1'b1, 32'h100}) begin fails++; $display("[TB] FAIL hold%0d: got %0h want %0h", i, {host_resp_valid, host_resp_data}, {1'b1, 32'h100}); end
      checks++; if ({cp_enable, cp_pcr, core_hold, host_req_ready} !== {1'b1, 5'd13, 1'b0, 1'b0}) begin fails++; $display("[TB] FAIL pass%0d: got %0h want %0h", i, {cp_enable, cp_pcr, core_hold, host_req_ready}, {1'b1, 5'd13, 1'b0, 1'b0}); end
    end
    core_enable = 0; core_stall = 0; core_pcr = 0;
    checks++; if (pcr_regs[3] !== 32'h100) begin fails++; $display("[TB] FAIL evec_kept: got %0h want 100", pcr_regs[3]); end
    host_resp_ready = 1;
    tick();
    host_resp_ready = 0;
    checks++; if (host_resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL hold_done: got %0h want 0", host_resp_valid); end
  endtask

  task automatic test_core_priority();
    @(negedge clk);
    core_enable = 1; core_stall = 0; core_cmd = 2'd1; core_pcr = 5'd13; core_wdata = 32'h55;
    host_req_valid = 1; host_req_write = 0; host_req_pcr = 5'd13;
    #1;
    checks++; if ({host_req_ready, core_hold} !== 2'b00) begin fails++; $display("[TB] FAIL prio_block: got %0h want 0", {host_req_ready, core_hold}); end
    checks++; if ({cp_stall, cp_pcr, cp_wdata} !== {1'b0, 5'd13, 32'h55}) begin fails++; $display("[TB] FAIL prio_cp: got %0h want %0h", {cp_stall, cp_pcr, cp_wdata}, {1'b0, 5'd13, 32'h55}); end
    @(negedge clk);
    core_enable = 0; core_cmd = 0; core_pcr = 0; core_wdata = 0;
    #1;
    checks++; if ({host_req_ready, cp_stall} !== 2'b11) begin fails++; $display("[TB] FAIL prio_grant: got %0h want 3", {host_req_ready, cp_stall}); end
    tick();
    host_req_valid = 0;
    checks++; if (host_resp_data !== 32'h55) begin fails++; $display("[TB] FAIL prio_rd: got %0h want 55", host_resp_data); end
    host_resp_ready = 1;
    tick();
    host_resp_ready = 0;
  endtask

  task automatic test_starvation();
    @(negedge clk);
    core_enable = 1; core_stall = 0; core_cmd = 2'd2; core_pcr = 5'd5; core_wdata = 32'h0;
    host_req_valid = 1; host_req_write = 0; host_req_pcr = 5'd12;
`ifdef PCR_ARB_STARVE_GUARD_EN
    for (int i = 1; i <= 9; i++) begin
      #1;
      checks++; if ({host_req_ready, core_hold} !== ((i == 9) ? 2'b11 : 2'b00)) begin fails++; $display("[TB] FAIL starve_c%0d: got %0h want %0h", i, {host_req_ready, core_hold}, (i == 9) ? 2'b11 : 2'b00); end
      @(negedge clk);
    end
    host_req_valid = 0;
    #1;
    checks++; if ({host_resp_valid, core_hold} !== 2'b10) begin fails++; $display("[TB] FAIL starve_after: got %0h want 2", {host_resp_valid, core_hold}); end
    checks++; if (host_resp_data !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL starve_rd: got %0h want deadbeef", host_resp_data); end
`else
    for (int i = 0; i < 50; i++) begin
      #1;
      checks++; if ({host_req_ready, core_hold} !== 2'b00) begin fails++; $display("[TB] FAIL starve_c%0d: got %0h want 0", i, {host_req_ready, core_hold}); end
      @(negedge clk);
    end
    host_req_valid = 0;
    #1;
    checks++; if (host_resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL starve_resp: got %0h want 0", host_resp_valid); end
`endif
    core_enable = 0; core_cmd = 0; core_pcr = 0;
    host_resp_ready = 1;
    tick();
    host_resp_ready = 0;
  endtask

  task automatic test_ptbr_flush();
    @(negedge clk);
    core_enable = 1; core_stall = 1; core_cmd = 2'd1; core_pcr = 5'd13; core_wdata = 32'h77;
    host_req_valid = 1; host_req_write = 1; host_req_pcr = 5'd7; host_req_wdata = 32'h2000;
    #1;
    checks++; if ({host_req_ready, core_hold, flush_tlb} !== 3'b111) begin fails++; $display("[TB] FAIL ptbr_grant: got %0h want 7", {host_req_ready, core_hold, flush_tlb}); end
    checks++; if (core_rdata !== 32'h0) begin fails++; $display("[TB] FAIL ptbr_crdata: got %0h want 0", core_rdata); end
    tick();
    host_req_valid = 0; core_enable = 0; core_stall = 0;
    checks++; if (pcr_regs[7] !== 32'h2000) begin fails++; $display("[TB] FAIL ptbr_val: got %0h want 2000", pcr_regs[7]); end
    checks++; if (pcr_regs[13] !== 32'h55) begin fails++; $display("[TB] FAIL k1_kept: got %0h want 55", pcr_regs[13]); end
    checks++; if ({host_resp_valid, host_resp_data} !== {1'b1, 32'h0}) begin fails++; $display("[TB] FAIL ptbr_resp: got %0h want %0h", {host_resp_valid, host_resp_data}, {1'b1, 32'h0}); end
    host_resp_ready = 1;
    tick();
    host_resp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_hold_response();
    test_core_priority();
    test_starvation();
    test_ptbr_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
